// File: rtl/ddr2_rd_data_checker.sv
// ddr2_rd_data_checker
// Compares each accepted read beat against ROM compare data through a
// three-register pipeline: capture, per-lane compare, then status/capture.
// Results appear two cycles after the sampling edge of read_data_valid.
module ddr2_rd_data_checker #(
  parameter int DQ_WIDTH       = 32,
  parameter int ERR_CNT_WIDTH  = 16,
  parameter int BEAT_CNT_WIDTH = 16
) (
  input  logic                      clk0,
  input  logic                      rst,
  input  logic                      chk_en,
  input  logic                      err_clr,
  input  logic                      read_data_valid,
  input  logic [2*DQ_WIDTH-1:0]     read_data_fifo_out,
  input  logic [2*DQ_WIDTH-1:0]     app_compare_data,
  output logic                      error_cmp,
  output logic                      error,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic [BEAT_CNT_WIDTH-1:0] beat_count,
  output logic [DQ_WIDTH/4-1:0]     err_lanes,
  output logic [DQ_WIDTH/4-1:0]     first_err_lanes,
  output logic [BEAT_CNT_WIDTH-1:0] first_err_beat,
  output logic [2*DQ_WIDTH-1:0]     first_err_rd_data,
  output logic [2*DQ_WIDTH-1:0]     first_err_exp_data,
  output logic [1:0]                chk_state
);

  localparam int DW    = 2 * DQ_WIDTH;
  localparam int LANES = DQ_WIDTH / 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } state_t;

  // One mismatch bit per byte lane.
  function automatic logic [LANES-1:0] lane_mismatch(input logic [DW-1:0] rd,
                                                     input logic [DW-1:0] ex);
    logic [LANES-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) begin
      m[k] = |(rd[8*k +: 8] ^ ex[8*k +: 8]);
    end
    return m;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                      vld_p1_q, vld_p2_q;
  logic [DW-1:0]             rd_p1_q, exp_p1_q, rd_p2_q, exp_p2_q;
  logic [LANES-1:0]          lanes_p2_q;
  logic                      mismatch_p2;
  logic                      error_cmp_q, error_q;
  logic [ERR_CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [LANES-1:0]          err_lanes_q, first_err_lanes_q;
  logic [BEAT_CNT_WIDTH-1:0] first_err_beat_q;
  logic [DW-1:0]             first_err_rd_q, first_err_exp_q;
  state_t                    state_q;

  // Stage 1: register the beat; a beat arriving with a clear is dropped.
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      rd_p1_q  <= '0;
      exp_p1_q <= '0;
    end else begin
      vld_p1_q <= read_data_valid & chk_en & ~err_clr;
      rd_p1_q  <= read_data_fifo_out;
      exp_p1_q <= app_compare_data;
    end
  end

  // Stage 2: per-lane compare; data travels along for first-error capture.
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      vld_p2_q   <= 1'b0;
      lanes_p2_q <= '0;
      rd_p2_q    <= '0;
      exp_p2_q   <= '0;
    end else begin
      vld_p2_q   <= vld_p1_q & ~err_clr;
      lanes_p2_q <= lane_mismatch(rd_p1_q, exp_p1_q);
      rd_p2_q    <= rd_p1_q;
      exp_p2_q   <= exp_p1_q;
    end
  end

  // Next values of the counters for a beat landing in stage 3.
  always_comb begin
    mismatch_p2  = vld_p2_q & (|lanes_p2_q);
    err_count_d  = sat_inc(err_count_q);
    beat_count_d = beat_count_q + 1'b1;
  end

  // Stage 3: visible status; clear overrides anything landing this cycle.
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst || err_clr) begin
      error_cmp_q       <= 1'b0;
      error_q           <= 1'b0;
      err_count_q       <= '0;
      beat_count_q      <= '0;
      err_lanes_q       <= '0;
      first_err_lanes_q <= '0;
      first_err_beat_q  <= '0;
      first_err_rd_q    <= '0;
      first_err_exp_q   <= '0;
    end else begin
      error_cmp_q <= mismatch_p2;
      if (vld_p2_q) begin
        err_lanes_q  <= lanes_p2_q;
        beat_count_q <= beat_count_d;
      end
      if (mismatch_p2) begin
        error_q     <= 1'b1;
        err_count_q <= err_count_d;
        // Only the first failure since reset/clear is captured (CHECK state).
        if (state_q == ST_CHECK) begin
          first_err_lanes_q <= lanes_p2_q;
          first_err_beat_q  <= beat_count_q;
          first_err_rd_q    <= rd_p2_q;
          first_err_exp_q   <= exp_p2_q;
        end
      end
    end
  end

  // Checker state: FAIL is sticky until a clear.
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst || err_clr) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (chk_en) state_q <= ST_CHECK;
        ST_CHECK: begin
          if (mismatch_p2)  state_q <= ST_FAIL;
          else if (!chk_en) state_q <= ST_IDLE;
        end
        ST_FAIL:  state_q <= ST_FAIL;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign error_cmp          = error_cmp_q;
  assign error              = error_q;
  assign err_count          = err_count_q;
  assign beat_count         = beat_count_q;
  assign err_lanes          = err_lanes_q;
  assign first_err_lanes    = first_err_lanes_q;
  assign first_err_beat     = first_err_beat_q;
  assign first_err_rd_data  = first_err_rd_q;
  assign first_err_exp_data = first_err_exp_q;
  assign chk_state          = state_q;

endmodule

// File: tb/tb_ddr2_rd_data_checker.sv
// Testbench for ddr2_rd_data_checker: directed scenarios followed by a random
// stream, all checked every cycle against a beat-queue reference model.
module tb_ddr2_rd_data_checker;

  localparam int DQW = 32;
  localparam int ECW = 4;
  localparam int BCW = 4;
  localparam int ECMAX = (1 << ECW) - 1;
  localparam int BCMOD = 1 << BCW;

  logic        clk0 = 1'b0;
  logic        rst, chk_en, err_clr, rdv;
  logic [63:0] rdata, cdata;
  logic        error_cmp, error;
  logic [3:0]  err_count, beat_count, first_err_beat;
  logic [7:0]  err_lanes, first_err_lanes;
  logic [63:0] first_err_rd_data, first_err_exp_data;
  logic [1:0]  chk_state;

  ddr2_rd_data_checker #(.DQ_WIDTH(DQW), .ERR_CNT_WIDTH(ECW), .BEAT_CNT_WIDTH(BCW)) dut (
    .clk0(clk0), .rst(rst), .chk_en(chk_en), .err_clr(err_clr),
    .read_data_valid(rdv), .read_data_fifo_out(rdata), .app_compare_data(cdata),
    .error_cmp(error_cmp), .error(error), .err_count(err_count), .beat_count(beat_count),
    .err_lanes(err_lanes), .first_err_lanes(first_err_lanes), .first_err_beat(first_err_beat),
    .first_err_rd_data(first_err_rd_data), .first_err_exp_data(first_err_exp_data),
    .chk_state(chk_state)
  );

  always #5 clk0 = ~clk0;

  // Reference model: accepted beats wait in a queue until their due edge.
  typedef struct {
    logic [63:0] rd;
    logic [63:0] ex;
    int          due;
  } beat_t;

  beat_t       pq[$];
  int          cyc_n = 0;
  int          m_cmp, m_err, m_ecnt, m_bcnt, m_lanes, m_flanes, m_fbeat, m_st;
  logic [63:0] m_frd, m_fexp;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int lanes_of(input logic [63:0] a, input logic [63:0] b);
    int r = 0;
    for (int k = 0; k < 8; k++)
      if (a[8*k +: 8] != b[8*k +: 8]) r = r | (1 << k);
    return r;
  endfunction

  task automatic model_reset();
    pq.delete();
    m_cmp = 0; m_err = 0; m_ecnt = 0; m_bcnt = 0; m_lanes = 0;
    m_flanes = 0; m_fbeat = 0; m_frd = '0; m_fexp = '0; m_st = 0;
  endtask

  task automatic model_edge();
    beat_t b;
    int    lanes;
    bit    land;
    cyc_n++;
    if (rst || err_clr) begin
      model_reset();
      return;
    end
    m_cmp = 0; land = 0; lanes = 0;
    if (pq.size() > 0 && pq[0].due == cyc_n) begin
      b = pq.pop_front();
      land = 1;
      lanes = lanes_of(b.rd, b.ex);
      m_lanes = lanes;
      if (lanes != 0) begin
        m_cmp = 1;
        m_err = 1;
        if (m_st == 1) begin
          m_flanes = lanes; m_fbeat = m_bcnt; m_frd = b.rd; m_fexp = b.ex;
        end
        m_ecnt = (m_ecnt == ECMAX) ? ECMAX : m_ecnt + 1;
      end
      m_bcnt = (m_bcnt + 1) % BCMOD;
    end
    if (m_st != 2)
      m_st = (land && lanes != 0 && m_st == 1) ? 2 : (chk_en ? 1 : 0);
    if (rdv && chk_en) pq.push_back('{rdata, cdata, cyc_n + 2});
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("error_cmp",       64'(error_cmp),       64'(m_cmp));
    check("error",           64'(error),           64'(m_err));
    check("err_count",       64'(err_count),       64'(m_ecnt));
    check("beat_count",      64'(beat_count),      64'(m_bcnt));
    check("err_lanes",       64'(err_lanes),       64'(m_lanes));
    check("first_err_lanes", 64'(first_err_lanes), 64'(m_flanes));
    check("first_err_beat",  64'(first_err_beat),  64'(m_fbeat));
    check("first_err_rd",    first_err_rd_data,    m_frd);
    check("first_err_exp",   first_err_exp_data,   m_fexp);
    check("chk_state",       64'(chk_state),       64'(m_st));
  endtask

  task automatic cyc();
    @(posedge clk0);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic beat(input logic [63:0] rd, input logic [63:0] ex);
    rdv = 1'b1; rdata = rd; cdata = ex;
    cyc();
    rdv = 1'b0;
  endtask

  task automatic idle(input int n);
    rdv = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clear();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] d, flip3rd;
    rst = 1'b1; chk_en = 1'b0; err_clr = 1'b0; rdv = 1'b0; rdata = '0; cdata = '0;
    model_reset();
    #1;
    check_all();
    idle(2);
    rst = 1'b0;

    // Matching stream of 8 identical beats.
    chk_en = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) beat(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    idle(2);
    check("tp_match_beats", 64'(beat_count), 64'd8);
    check("tp_match_state", 64'(chk_state), 64'd1);

    // Single-lane error on beat 3 (bit 17, lane 2).
    clear();
    flip3rd = '0;
    for (int i = 0; i < 6; i++) begin
      d = rnd64();
      if (i == 3) flip3rd = d ^ (64'd1 << 17);
      beat((i == 3) ? flip3rd : d, d);
    end
    idle(2);
    check("tp_single_lanes", 64'(first_err_lanes), 64'h04);
    check("tp_single_beat",  64'(first_err_beat),  64'd3);
    check("tp_single_rd",    first_err_rd_data,    flip3rd);
    check("tp_single_state", 64'(chk_state),       64'd2);

    // Two errors: beat 2 lane 0, beat 5 lane 7.
    clear();
    idle(1);
    for (int i = 0; i < 8; i++) begin
      d = rnd64();
      beat((i == 2) ? d ^ 64'd1 : (i == 5) ? d ^ (64'd1 << 63) : d, d);
    end
    idle(2);
    check("tp_multi_flanes", 64'(first_err_lanes), 64'h01);
    check("tp_multi_fbeat",  64'(first_err_beat),  64'd2);
    check("tp_multi_ecnt",   64'(err_count),       64'd2);

    // Error counter saturation.
    clear();
    for (int i = 0; i < 20; i++) begin
      d = rnd64();
      beat(d ^ (64'd1 << $urandom_range(0, 63)), d);
    end
    idle(2);
    check("tp_sat_ecnt", 64'(err_count), 64'hF);

    // Beat counter wrap.
    clear();
    for (int i = 0; i < 17; i++) begin
      d = rnd64();
      beat(d, d);
    end
    idle(2);
    check("tp_wrap_bcnt", 64'(beat_count), 64'd1);

    // Gating and drain: chk_en falls with two mismatches in flight.
    d = rnd64(); beat(d ^ 64'h100, d);
    d = rnd64(); beat(d ^ 64'h100, d);
    chk_en = 1'b0;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      d = rnd64();
      beat(d ^ 64'h1, d);
    end
    idle(3);
    check("tp_gate_ecnt",  64'(err_count),  64'd2);
    check("tp_gate_bcnt",  64'(beat_count), 64'd3);
    check("tp_gate_state", 64'(chk_state),  64'd2);

    // Clear landing on the same edge as a stage-3 mismatch.
    chk_en = 1'b1;
    clear();
    idle(1);
    d = rnd64(); beat(d ^ 64'hFF00, d);
    idle(1);
    clear();
    check("tp_coll_ecnt",  64'(err_count), 64'd0);
    check("tp_coll_error", 64'(error),     64'd0);
    check("tp_coll_idle",  64'(chk_state), 64'd0);
    idle(1);
    check("tp_coll_check", 64'(chk_state), 64'd1);

    // Random stream.
    for (int i = 0; i < 400; i++) begin
      chk_en  = ($urandom_range(0, 9) != 0);
      err_clr = ($urandom_range(0, 29) == 0);
      rdv     = ($urandom_range(0, 3) != 0);
      d = rnd64();
      cdata = d;
      rdata = ($urandom_range(0, 4) == 0) ? d ^ (64'd1 << $urandom_range(0, 63)) : d;
      cyc();
    end
    err_clr = 1'b0;

    // Asynchronous reset in the middle of a mismatching stream.
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = rnd64();
      beat(d ^ 64'h8000, d);
    end
    rdv = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("tp_async_ecnt", 64'(err_count), 64'd0);
    cyc();
    rst = 1'b0;
    rdv = 1'b0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
